// File: rtl/timer_pkg.sv
// Shared types and constants for the 16-bit countdown timer.
// The state encoding is fixed at 2 bits so it can be probed on the board LEDs.
package timer_pkg;

    localparam int CNT_W            = 16;
    localparam int DEFAULT_PRESCALE = 50_000_000;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        PAUSE   = 2'b10,
        EXPIRED = 2'b11
    } state_t;

    // Registered outputs, grouped so their next values are produced by one process.
    typedef struct packed {
        logic busy;
        logic done;
        logic expired;
    } status_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and flags the last one.
// A paused count (En low) keeps its value, so sub-tick time survives a pause.
module tick_gen
    import timer_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic Clk,
    input  logic Clr,
    input  logic En,
    input  logic SyncClr,
    output logic Tick
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] count;

    assign Tick = En && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            count <= '0;
        end else if (SyncClr) begin
            count <= '0;
        end else if (En) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer16.sv
// Loadable 16-bit down-counting timer: decrements once per prescaled tick while
// running, stops at zero, pulses Done and holds Expired until the next Load.
module countdown_timer16
    import timer_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int WIDTH    = CNT_W
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic             Stop,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done,
    output logic             Expired
);

    state_t           state;
    state_t           state_next;
    status_t          status_next;
    logic [WIDTH-1:0] q_next;
    logic             tick;
    logic             sync_clr;
    logic             last_tick;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .Clk     (Clk),
        .Clr     (Clr),
        .En      (state == RUN),
        .SyncClr (sync_clr),
        .Tick    (tick)
    );

    // The tick that takes Q from 1 to 0 ends the run even if Stop arrives with it.
    assign last_tick = (state == RUN) && tick && (Q == WIDTH'(1));

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        sync_clr   = Load;
        if (Load) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start && !Stop && (Q != '0)) begin
                        state_next = RUN;
                        sync_clr   = 1'b1;
                    end
                end
                RUN: begin
                    if (last_tick) begin
                        state_next = EXPIRED;
                    end else if (Stop) begin
                        state_next = PAUSE;
                    end
                end
                PAUSE: begin
                    if (Start && !Stop) begin
                        state_next = RUN;
                    end
                end
                EXPIRED: state_next = EXPIRED;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        status_next.busy    = (state_next == RUN);
        status_next.expired = (state_next == EXPIRED);
        status_next.done    = !Load && last_tick;
    end

    // Q only moves on a running tick, and never below zero.
    always_comb begin
        q_next = Q;
        if (Load) begin
            q_next = D;
        end else if ((state == RUN) && tick && (Q != '0)) begin
            q_next = Q - WIDTH'(1);
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            Q       <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Expired <= 1'b0;
        end else begin
            Q       <= q_next;
            Busy    <= status_next.busy;
            Done    <= status_next.done;
            Expired <= status_next.expired;
        end
    end

endmodule

// File: tb/tb_countdown_timer16.sv
// Self-checking bench for countdown_timer16 with PRESCALE=4: an elapsed-time
// model checked every cycle plus directed literal expectations.
module tb_countdown_timer16;

    localparam int P = 4;

    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic        Load = 1'b0;
    logic [15:0] D = '0;
    logic        Start = 1'b0;
    logic        Stop = 1'b0;
    logic [15:0] Q;
    logic        Busy;
    logic        Done;
    logic        Expired;

    int tests    = 0;
    int failures = 0;
    bit check_en = 1'b0;

    countdown_timer16 #(.PRESCALE(P), .WIDTH(16)) dut (
        .Clk     (Clk),
        .Clr     (Clr),
        .Load    (Load),
        .D       (D),
        .Start   (Start),
        .Stop    (Stop),
        .Q       (Q),
        .Busy    (Busy),
        .Done    (Done),
        .Expired (Expired)
    );

    always #5 Clk = ~Clk;

    // Model: Q is the loaded value minus whole ticks of accumulated running time.
    int m_loaded  = 0;
    int m_elapsed = 0;
    bit m_run     = 0;
    bit m_paused  = 0;
    bit m_exp     = 0;
    bit m_done    = 0;

    function automatic int model_q();
        return m_loaded - (m_elapsed / P);
    endfunction

    always @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            m_loaded = 0; m_elapsed = 0;
            m_run = 0; m_paused = 0; m_exp = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (Load) begin
                m_loaded = int'(D); m_elapsed = 0;
                m_run = 0; m_paused = 0; m_exp = 0;
            end else if (m_run) begin
                m_elapsed++;
                if (m_elapsed == m_loaded * P) begin
                    m_run = 0; m_exp = 1; m_done = 1;
                end else if (Stop) begin
                    m_run = 0; m_paused = 1;
                end
            end else if (!m_exp && Start && !Stop && model_q() != 0) begin
                m_run = 1; m_paused = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (check_en && Clr) begin
            check("model_q",       32'(Q),       32'(model_q()));
            check("model_busy",    32'(Busy),    32'(m_run));
            check("model_done",    32'(Done),    32'(m_done));
            check("model_expired", 32'(Expired), 32'(m_exp));
        end
    end

    task automatic drive(input logic l, input logic [15:0] d, input logic st, input logic sp);
        Load = l; D = d; Start = st; Stop = sp;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        cycles(2);
        check("reset_q",       32'(Q),       32'h0);
        check("reset_busy",    32'(Busy),    32'h0);
        check("reset_done",    32'(Done),    32'h0);
        check("reset_expired", 32'(Expired), 32'h0);
        Clr = 1'b1;
        check_en = 1'b1;

        // Basic countdown from 3.
        drive(1, 16'd3, 0, 0); cycles(1);
        check("load3_q", 32'(Q), 32'd3);
        drive(0, 0, 1, 0); cycles(1);
        check("start_busy", 32'(Busy), 32'd1);
        drive(0, 0, 0, 0); cycles(3);
        check("pre_tick_q", 32'(Q), 32'd3);
        cycles(1);
        check("tick4_q", 32'(Q), 32'd2);
        cycles(4);
        check("tick8_q", 32'(Q), 32'd1);
        check("tick8_done", 32'(Done), 32'd0);
        cycles(4);
        check("tick12_q", 32'(Q), 32'd0);
        check("tick12_done", 32'(Done), 32'd1);
        check("tick12_expired", 32'(Expired), 32'd1);
        check("tick12_busy", 32'(Busy), 32'd0);
        cycles(1);
        check("done_one_cycle", 32'(Done), 32'd0);
        cycles(20);
        check("hold_zero_q", 32'(Q), 32'd0);
        check("hold_expired", 32'(Expired), 32'd1);

        // Pause and resume keep sub-tick time.
        drive(1, 16'd5, 0, 0); cycles(1);
        drive(0, 0, 1, 0); cycles(1);
        drive(0, 0, 0, 0); cycles(5);
        drive(0, 0, 0, 1); cycles(1);
        check("pause_q", 32'(Q), 32'd4);
        check("pause_busy", 32'(Busy), 32'd0);
        drive(0, 0, 0, 0); cycles(10);
        check("paused_hold_q", 32'(Q), 32'd4);
        drive(0, 0, 1, 0); cycles(1);
        check("resume_busy", 32'(Busy), 32'd1);
        drive(0, 0, 0, 0); cycles(1);
        check("resume_plus1_q", 32'(Q), 32'd4);
        cycles(1);
        check("resume_plus2_q", 32'(Q), 32'd3);

        // Asynchronous clear between edges.
        cycles(2);
        @(posedge Clk); #2 Clr = 1'b0;
        #1;
        check("clr_async_q",    32'(Q),    32'd0);
        check("clr_async_busy", 32'(Busy), 32'd0);
        check("clr_async_done", 32'(Done), 32'd0);
        #1 Clr = 1'b1;
        @(negedge Clk);
        drive(0, 0, 1, 0); cycles(1);
        check("start_zero_ignored", 32'(Busy), 32'd0);

        // Load during RUN, then full-scale load.
        drive(1, 16'd10, 0, 0); cycles(1);
        drive(0, 0, 1, 0); cycles(1);
        drive(0, 0, 0, 0); cycles(6);
        drive(1, 16'h00FF, 0, 0); cycles(1);
        check("load_in_run_q", 32'(Q), 32'h00FF);
        check("load_in_run_busy", 32'(Busy), 32'd0);
        drive(1, 16'hFFFF, 0, 0); cycles(1);
        drive(0, 0, 1, 0); cycles(1);
        drive(0, 0, 0, 0); cycles(3);
        check("ffff_hold_q", 32'(Q), 32'hFFFF);
        cycles(1);
        check("ffff_dec_q", 32'(Q), 32'hFFFE);

        // Start+Stop together: Stop wins in RUN and in PAUSE.
        cycles(5);
        drive(0, 0, 1, 1); cycles(1);
        check("startstop_busy", 32'(Busy), 32'd0);
        check("startstop_q", 32'(Q), 32'hFFFD);
        cycles(2);
        check("startstop_pause_busy", 32'(Busy), 32'd0);
        check("startstop_pause_q", 32'(Q), 32'hFFFD);

        // EXPIRED ignores Start/Stop; Load leaves it.
        drive(1, 16'd1, 0, 0); cycles(1);
        drive(0, 0, 1, 0); cycles(1);
        drive(0, 0, 0, 0); cycles(4);
        check("one_done", 32'(Done), 32'd1);
        drive(0, 0, 1, 0); cycles(3);
        check("exp_start_busy", 32'(Busy), 32'd0);
        check("exp_start_expired", 32'(Expired), 32'd1);
        drive(0, 0, 0, 1); cycles(2);
        check("exp_stop_expired", 32'(Expired), 32'd1);
        drive(1, 16'd2, 0, 0); cycles(1);
        check("exp_load_expired", 32'(Expired), 32'd0);
        check("exp_load_q", 32'(Q), 32'd2);

        // Load 0 goes to IDLE, and Start there is ignored.
        drive(1, 16'd0, 0, 0); cycles(1);
        check("load0_expired", 32'(Expired), 32'd0);
        drive(0, 0, 1, 0); cycles(2);
        check("load0_start_busy", 32'(Busy), 32'd0);
        check("load0_start_q", 32'(Q), 32'd0);

        // Held Load keeps reloading even with Start.
        drive(1, 16'd7, 1, 0); cycles(6);
        check("held_load_q", 32'(Q), 32'd7);
        check("held_load_busy", 32'(Busy), 32'd0);
        drive(0, 0, 0, 0); cycles(2);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
